int_to_half_encoder: RTL

Sequential converter from a 16-bit integer to IEEE 754 half precision: 1 sign bit, 5-bit exponent with bias 15, and 10-bit mantissa. It is the producer side of the half-float adder datapath and generates that adder's operand format from integer sources. It uses iterative left-shift normalization and round-to-nearest-even. Valid/ready handshakes sit on both sides, and at most one conversion is in flight.

---
 rtl/half_float_pkg.sv | 27 ++
 rtl/half_round_rne.sv | 51 +++++
 rtl/int_to_half_encoder.sv | 113 +++++++++++
 3 files changed

// File: rtl/half_float_pkg.sv
// Shared definitions for the half-precision float blocks: field widths,
// controller states and a field packing helper.
`default_nettype none

package half_float_pkg;

  localparam int unsigned EXP_W    = 5;
  localparam int unsigned MANT_W   = 10;
  localparam int unsigned EXP_BIAS = 15;
  localparam logic [EXP_W-1:0] EXP_INF = 5'b11111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [15:0] pack_half(input logic             sign,
                                            input logic [EXP_W-1:0]  exp,
                                            input logic [MANT_W-1:0] mant);
    return {sign, exp, mant};
  endfunction

endpackage

`default_nettype wire

// File: rtl/half_round_rne.sv
// Round-to-nearest-even of a normalized 16-bit magnitude to a 10-bit mantissa,
// with exponent carry and overflow-to-infinity detection.
`default_nettype none

module half_round_rne
  import half_float_pkg::*;
(
  input  logic [15:0]       mag,
  input  logic [EXP_W-1:0]  exp_in,
  output logic [EXP_W-1:0]  exp_out,
  output logic [MANT_W-1:0] mant_out,
  output logic              inexact,
  output logic              overflow
);

  logic [MANT_W-1:0] mant;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [MANT_W:0]   mant_sum;
  logic [EXP_W:0]    exp_sum;
  logic              normalized;

  // mag[15] is the hidden one; an unnormalized operand can only be zero.
  assign normalized = mag[15];
  assign mant       = mag[14:5];
  assign guard      = mag[4];
  assign sticky     = |mag[3:0];
  assign round_up   = guard & (sticky | mant[0]);
  assign mant_sum   = {1'b0, mant} + {{MANT_W{1'b0}}, round_up};
  assign exp_sum    = {1'b0, exp_in} + {{EXP_W{1'b0}}, mant_sum[MANT_W]};

  always_comb begin
    exp_out  = exp_sum[EXP_W-1:0];
    mant_out = mant_sum[MANT_W-1:0];
    inexact  = guard | sticky;
    overflow = 1'b0;
    if (!normalized) begin
      exp_out  = '0;
      mant_out = '0;
      inexact  = 1'b0;
    end else if (exp_sum >= {1'b0, EXP_INF}) begin
      exp_out  = EXP_INF;
      mant_out = '0;
      overflow = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/int_to_half_encoder.sv
// 16-bit integer to IEEE 754 half-precision converter: iterative left-shift
// normalization, round-to-nearest-even, valid/ready on both sides.
`default_nettype none

module int_to_half_encoder
  import half_float_pkg::*;
#(
  parameter bit SIGNED_IN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_inexact,
  output logic        out_overflow
);

  state_t state, state_nxt;

  logic        sign_r;
  logic [15:0] mag_r;
  logic [3:0]  k_r;

  logic        in_sign;
  logic [15:0] in_mag;

  logic [EXP_W-1:0]  exp_norm;
  logic [EXP_W-1:0]  rnd_exp;
  logic [MANT_W-1:0] rnd_mant;
  logic              rnd_inexact;
  logic              rnd_overflow;

  // Negating -32768 wraps back to 16'h8000, which is the correct magnitude.
  assign in_sign  = SIGNED_IN & in_data[15];
  assign in_mag   = in_sign ? (~in_data + 16'd1) : in_data;
  assign exp_norm = 5'd30 - {1'b0, k_r};

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  half_round_rne u_round (
    .mag      (mag_r),
    .exp_in   (exp_norm),
    .exp_out  (rnd_exp),
    .mant_out (rnd_mant),
    .inexact  (rnd_inexact),
    .overflow (rnd_overflow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = (in_mag == 16'd0) ? DONE : NORM;
      NORM:    if (mag_r[15]) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_r       <= 1'b0;
      mag_r        <= 16'd0;
      k_r          <= 4'd0;
      out_data     <= 16'h0000;
      out_inexact  <= 1'b0;
      out_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_r <= in_sign;
            mag_r  <= in_mag;
            k_r    <= 4'd0;
            if (in_mag == 16'd0) begin
              out_data     <= 16'h0000;
              out_inexact  <= 1'b0;
              out_overflow <= 1'b0;
            end
          end
        end
        NORM: begin
          if (!mag_r[15]) begin
            mag_r <= {mag_r[14:0], 1'b0};
            k_r   <= k_r + 4'd1;
          end
        end
        ROUND: begin
          out_data     <= pack_half(sign_r, rnd_exp, rnd_mant);
          out_inexact  <= rnd_inexact;
          out_overflow <= rnd_overflow;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
